mesi_isc_broad_arb: RTL and testbench

// - Shares the broadcast-request FIFO write port between the 4 CPU request sources.
// - Picks one valid source per cycle (round-robin), tags it with the initiator CPU id and a fresh

---
 rtl/mesi_isc_broad_pkg.sv | 16 +
 rtl/mesi_isc_broad_rr_pick.sv | 33 +++
 rtl/mesi_isc_broad_arb.sv | 96 +++++++++
 tb/tb_mesi_isc_broad_arb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mesi_isc_broad_pkg.sv
// Shared constants and the staged broadcast request record for the broadcast arbiter.
package mesi_isc_broad_pkg;

    localparam int CPU_NUM          = 4;
    localparam int ADDR_WIDTH       = 32;
    localparam int BROAD_TYPE_WIDTH = 2;
    localparam int BROAD_ID_WIDTH   = 5;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       addr;
        logic [BROAD_TYPE_WIDTH-1:0] broad_type;
        logic [1:0]                  cpu_id;
        logic [BROAD_ID_WIDTH-1:0]   id;
    } broad_req_t;

endpackage

// File: rtl/mesi_isc_broad_rr_pick.sv
// 4-way round-robin picker: one-hot grant of the first eligible source at or after rr_ptr.
module mesi_isc_broad_rr_pick
    import mesi_isc_broad_pkg::*;
(
    input  logic [CPU_NUM-1:0] valid,
    input  logic [CPU_NUM-1:0] mask,
    input  logic [1:0]         rr_ptr,
    output logic [CPU_NUM-1:0] grant,
    output logic [1:0]         idx
);

    logic [CPU_NUM-1:0] elig;
    logic [1:0]         k;
    logic               found;

    assign elig = valid & ~mask;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < CPU_NUM; i++) begin
            k = rr_ptr + 2'(i);
            if (!found && elig[k]) begin
                grant[k] = 1'b1;
                idx      = k;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_broad_arb.sv
// Broadcast FIFO write-port arbiter: round-robin over 4 CPUs into a 1-entry stage.
// Optional MESI_ISC_BROAD_ARB_ADDR_BLOCK_EN masks sources whose address matches the staged one.
module mesi_isc_broad_arb #(
    parameter int ADDR_WIDTH       = mesi_isc_broad_pkg::ADDR_WIDTH,
    parameter int BROAD_TYPE_WIDTH = mesi_isc_broad_pkg::BROAD_TYPE_WIDTH,
    parameter int BROAD_ID_WIDTH   = mesi_isc_broad_pkg::BROAD_ID_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    req_valid_array_i,
    input  logic [4*ADDR_WIDTH-1:0]       req_addr_array_i,
    input  logic [4*BROAD_TYPE_WIDTH-1:0] req_type_array_i,
    output logic [3:0]                    req_ready_array_o,
    input  logic                          fifo_status_full_i,
    output logic                          broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]         broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
    output logic [1:0]                    broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]     broad_id_o,
    output logic                          arb_busy_o
);

    import mesi_isc_broad_pkg::CPU_NUM;

    logic [CPU_NUM-1:0][ADDR_WIDTH-1:0]       req_addr;
    logic [CPU_NUM-1:0][BROAD_TYPE_WIDTH-1:0] req_type;

    logic                        hold_valid;
    logic [ADDR_WIDTH-1:0]       hold_addr;
    logic [BROAD_TYPE_WIDTH-1:0] hold_type;
    logic [1:0]                  hold_cpu_id;
    logic [BROAD_ID_WIDTH-1:0]   hold_id;
    logic [1:0]                  rr_ptr;
    logic [BROAD_ID_WIDTH-1:0]   id_cnt;

    logic               can_load;
    logic               xfer;
    logic [CPU_NUM-1:0] mask;
    logic [CPU_NUM-1:0] grant;
    logic [1:0]         pick_idx;

    assign req_addr = req_addr_array_i;
    assign req_type = req_type_array_i;

`ifdef MESI_ISC_BROAD_ARB_ADDR_BLOCK_EN
    // Keep a second request to the staged line out until the stage empties.
    for (genvar g = 0; g < CPU_NUM; g++) begin : g_mask
        assign mask[g] = hold_valid & (req_addr[g] == hold_addr);
    end
`else
    assign mask = '0;
`endif

    mesi_isc_broad_rr_pick u_pick (
        .valid  (req_valid_array_i),
        .mask   (mask),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (pick_idx)
    );

    assign broad_fifo_wr_o = hold_valid & ~fifo_status_full_i;
    assign can_load        = ~hold_valid | broad_fifo_wr_o;
    // Gated by rst so no requester sees an accept that the reset will discard.
    assign req_ready_array_o = (can_load & ~rst) ? grant : '0;
    assign xfer              = |req_ready_array_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid  <= 1'b0;
            hold_addr   <= '0;
            hold_type   <= '0;
            hold_cpu_id <= '0;
            hold_id     <= '0;
            rr_ptr      <= '0;
            id_cnt      <= '0;
        end else if (xfer) begin
            hold_valid  <= 1'b1;
            hold_addr   <= req_addr[pick_idx];
            hold_type   <= req_type[pick_idx];
            hold_cpu_id <= pick_idx;
            hold_id     <= id_cnt;
            rr_ptr      <= pick_idx + 2'd1;
            id_cnt      <= id_cnt + 1'b1;
        end else if (broad_fifo_wr_o) begin
            hold_valid  <= 1'b0;
        end
    end

    assign broad_addr_o   = hold_addr;
    assign broad_type_o   = hold_type;
    assign broad_cpu_id_o = hold_cpu_id;
    assign broad_id_o     = hold_id;
    assign arb_busy_o     = hold_valid;

endmodule

// File: tb/tb_mesi_isc_broad_arb.sv
// Directed bench for mesi_isc_broad_arb; honours MESI_ISC_BROAD_ARB_ADDR_BLOCK_EN for the masking case.
module tb_mesi_isc_broad_arb;
    import mesi_isc_broad_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   valid;
    logic [127:0] addr_arr;
    logic [7:0]   type_arr;
    logic [3:0]   ready;
    logic         full;
    logic         wr;
    logic [31:0]  b_addr;
    logic [1:0]   b_type;
    logic [1:0]   b_cpu;
    logic [4:0]   b_id;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    broad_req_t exp_req;

    always #5 clk = ~clk;

    mesi_isc_broad_arb dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_array_i  (valid),
        .req_addr_array_i   (addr_arr),
        .req_type_array_i   (type_arr),
        .req_ready_array_o  (ready),
        .fifo_status_full_i (full),
        .broad_fifo_wr_o    (wr),
        .broad_addr_o       (b_addr),
        .broad_type_o       (b_type),
        .broad_cpu_id_o     (b_cpu),
        .broad_id_o         (b_id),
        .arb_busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point: 1 time unit after the rising edge; checks happen 4 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [1:0] t);
        addr_arr[k*32 +: 32] = a;
        type_arr[k*2 +: 2]   = t;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; valid = '0; full = 1'b0;
        #4;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 4'b1111; full = 1'b0; addr_arr = '0; type_arr = '0;
        repeat (2) @(posedge clk);
        #5;
        chk("rst_ready", ready, 4'b0000);
        chk("rst_wr", wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", b_addr, 0);
        chk("rst_id", b_id, 0);
        chk("rst_cpu", b_cpu, 0);
        tick();
        rst = 1'b0; valid = '0;
        #4;
        chk("post_rst_ready", ready, 4'b0000);

        // T1
        tick();
        set_req(2, 32'h100, 2'd1); valid = 4'b0100;
        #4;
        chk("t1_ready", ready, 4'b0100);
        tick();
        valid = '0;
        #4;
        exp_req = '{addr: 32'h100, broad_type: 2'd1, cpu_id: 2'd2, id: 5'd0};
        chk("t1_wr", wr, 1);
        chk("t1_addr", b_addr, exp_req.addr);
        chk("t1_type", b_type, exp_req.broad_type);
        chk("t1_cpu", b_cpu, exp_req.cpu_id);
        chk("t1_id", b_id, exp_req.id);
        tick();
        #4;
        chk("t1_drained", busy, 0);

        // T2
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 32'h1000 + 32'(k) * 32'h10, 2'(k));
        valid = 4'b1111;
        #4;
        chk("t2_ready0", ready, 4'b0001);
        chk("t2_wr0", wr, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            #4;
            chk("t2_ready", ready, 64'(4'b0001 << (i % 4)));
            chk("t2_wr", wr, 1);
            chk("t2_cpu", b_cpu, 64'((i - 1) % 4));
            chk("t2_id", b_id, 64'(i - 1));
        end

        // T3: stage now holds CPU1 id5
        tick();
        full = 1'b1;
        #4;
        for (int i = 0; i < 3; i++) begin
            chk("t3_wr", wr, 0);
            chk("t3_ready", ready, 4'b0000);
            chk("t3_cpu", b_cpu, 1);
            chk("t3_id", b_id, 5);
            chk("t3_addr", b_addr, 32'h1010);
            tick();
            #4;
        end
        tick();
        full = 1'b0;
        #4;
        chk("t3_wr_drop", wr, 1);
        chk("t3_ready_drop", ready, 4'b0100);
        chk("t3_id_drop", b_id, 5);
        tick();
        valid = '0;

        // T4: ID counter wraps after 32 transfers
        do_reset();
        for (int i = 0; i < 33; i++) begin
            tick();
            set_req(1, 32'h2000 + 32'(i) * 4, 2'd2); valid = 4'b0010;
            #4;
            chk("t4_ready", ready, 4'b0010);
            tick();
            valid = '0;
            #4;
            chk("t4_id", b_id, 64'(i % 32));
            chk("t4_addr", b_addr, 64'(32'h2000 + 32'(i) * 4));
        end

        // T5: reset while a staged request is blocked
        tick();
        set_req(2, 32'h300, 2'd3); valid = 4'b0100; full = 1'b1;
        #4;
        chk("t5_load_ready", ready, 4'b0100);
        tick();
        valid = '0;
        #4;
        chk("t5_busy", busy, 1);
        chk("t5_wr_full", wr, 0);
        rst = 1'b1; valid = 4'b1111;
        #1;
        chk("t5_rst_wr", wr, 0);
        chk("t5_rst_ready", ready, 4'b0000);
        chk("t5_rst_busy", busy, 0);
        tick();
        rst = 1'b0; full = 1'b0;
        #4;
        chk("t5_first_ready", ready, 4'b0001);
        tick();
        valid = '0;
        #4;
        chk("t5_cpu", b_cpu, 0);
        chk("t5_id", b_id, 0);
        chk("t5_wr", wr, 1);

        // T6: stage holds 0x40 with rr_ptr=1
        tick();
        set_req(0, 32'h40, 2'd0); valid = 4'b0001;
        #4;
        chk("t6_load", ready, 4'b0001);
        tick();
        full = 1'b1;
        set_req(1, 32'h40, 2'd1); set_req(3, 32'h80, 2'd1); valid = 4'b1010;
        #4;
        chk("t6_full_ready", ready, 4'b0000);
        chk("t6_addr", b_addr, 32'h40);
        tick();
        full = 1'b0;
        #4;
        chk("t6_wr", wr, 1);
`ifdef MESI_ISC_BROAD_ARB_ADDR_BLOCK_EN
        chk("t6_grant", ready, 4'b1000);
`else
        chk("t6_grant", ready, 4'b0010);
`endif
        tick();
        valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
